pc_stage_sequencer: RTL
=======================

// Module: pc_stage_sequencer
// PURPOSE
//  Parametrised stage sequencer and PC/next-PC unit for the multicycle core.
//  Steps the instruction through NUM_STAGES stages (fetch .. execute/writeback), holds on stall.
//  In the final stage, resolves branches (all six RV32 conditions), jal and jalr, then loads the new PC.
//  Replaces the fixed 3-stage, beq-only control path. Sits between the memory interface and the datapath.
// PARAMETERS
//  XLEN        32            datapath/PC width
//  NUM_STAGES  3             stages per instruction, >=2; stage 0 = fetch, NUM_STAGES-1 = execute/writeback
//  RESET_PC    32'h8000_0000 PC value on reset (truncated to XLEN)
//  STW         $clog2(NUM_STAGES) stage index width (derived, do not override)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  stall_i      in   1     current stage not complete (e.g. memory wait)
//  instr_i      in   32    instruction word; used only while stage_o==NUM_STAGES-1
//  rs1_i        in   XLEN  rs1 value
//  rs2_i        in   XLEN  rs2 value
//  stage_o      out  STW   current stage index
//  advance_o    out  1     combinational: stage completes at the next edge
//  pc_o         out  XLEN  PC of the instruction in flight
//  link_o       out  XLEN  pc_o+4; link value for jal/jalr
//  redirect_o   out  1     combinational: final stage, advancing, taken branch/jal/jalr
//  retire_o     out  1     registered one-cycle pulse after each final-stage advance
//  trap_o       out  1     misaligned-target trap (MISALIGN_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  - Reset, async: stage_o=0, pc_o=RESET_PC, retire_o=0, trap_o=0. advance_o/redirect_o follow combinationally.
//  - advance_o = !stall_i & !trap_o. While 0, stage_o and pc_o hold indefinitely.
//  - Advance in stage k<NUM_STAGES-1: stage k+1 next cycle. PC unchanged.
//  - Advance in final stage: stage 0 and pc_o<=next_pc next cycle; retire_o=1 for that one cycle.
//  - Latency per instruction: NUM_STAGES cycles minimum, plus one cycle per stalled cycle.
//  - next_pc decode, opcode = instr_i[6:0]:
//      1100011 branch, by funct3: 000 eq, 001 ne, 100 lt (signed), 101 ge (signed), 110 ltu, 111 geu.
//        Taken: pc+B-imm. Not taken: pc+4. funct3 010/011 count as not taken.
//      1101111 jal:  pc+J-imm, always taken.
//      1100111 jalr: (rs1+I-imm) & ~1, always taken.
//      any other opcode: pc+4, redirect_o=0.
//  - Immediates are sign-extended to XLEN. All adds wrap modulo 2^XLEN (pc 0xFFFF_FFFC+4 -> 0).
//  - redirect_o = final stage & advance_o & taken. It is 0 in all other stages, whatever instr_i holds.
//  - Reset mid-instruction discards it: no retire_o pulse, PC reloads RESET_PC.
//  - Simultaneous stall_i and final stage: no PC update, no retire_o.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    A taken target with target[1:0]!=0 in the final stage sets trap_o (sticky until rst).
//    pc_o keeps the faulting instruction's PC; stage returns to 0; retire_o not pulsed.
//    advance_o is forced 0 from then on.
//  MISALIGN_TRAP_EN undefined:
//    trap_o tied 0. A misaligned target (bit 1 set) loads into pc_o unchanged.
//    jalr still clears bit 0.
// TESTING
//  1 beq x1,x2,1024 (0x40208063), rs1=0xFFF, rs2=-0xFFF, pc 0x8000_0000 -> after 3 advances pc_o=0x8000_0004, redirect_o never 1
//  2 beq 16 (0x00308863) at pc 0x8000_0004, rs1=rs2=0xFFF -> redirect_o=1 in stage 2; pc_o=0x8000_0014
//  3 beq -4 (0xFE308EE3) at pc 0x8000_0010, equal -> pc_o=0x8000_000C; bltu 1<0xFFFF_FFFF taken; blt 1<-1 not taken
//  4 jal x5,512 (0x200002EF) at 0x8000_0000 -> pc_o=0x8000_0200, link_o=0x8000_0004 in final stage
//  5 jalr x5,512(x4) (0x200202E7), rs1=0x8000_1200 -> pc_o=0x8000_1400; rs1=0x8000_1201 -> 0x8000_1400 (bit0 cleared)
//  6 stall_i=1 for 5 cycles in stage 1 -> stage_o=1, advance_o=0 throughout; then rst at stage 2 -> stage_o=0, pc_o=RESET_PC, no retire_o
//  7 (MISALIGN_TRAP_EN) beq +2 taken -> trap_o=1, pc_o holds, advance_o=0 until rst

Source files
------------

// File: rtl/pc_stage_sequencer.sv
// pc_stage_sequencer
// Parametrised stage sequencer and PC/next-PC unit for the multicycle core.
// It steps each instruction through NUM_STAGES stages and holds while stall_i is set.
// In the final stage it resolves branches (eq/ne/lt/ge/ltu/geu), jal and jalr, then loads the new PC.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a misaligned taken target raises a
// sticky trap_o. When it is undefined, trap_o is tied to 0.
module pc_stage_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_STAGES = 3,
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned STW        = $clog2(NUM_STAGES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [STW-1:0]  stage_o,
  output logic            advance_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] link_o,
  output logic            redirect_o,
  output logic            retire_o,
  output logic            trap_o
);

  localparam logic [STW-1:0]  LAST_STAGE = STW'(NUM_STAGES - 1);
  localparam logic [XLEN-1:0] PC_INIT    = XLEN'(RESET_PC);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [STW-1:0]  stage_q, stage_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            retire_q, retire_d;
  logic            trap_q, trap_d;

  logic            is_last;
  logic            advance;
  logic            taken;
  logic            br_cond;
  logic            misalign;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] i_imm;
  logic [6:0]      opcode;
  logic [2:0]      funct3;

  // Sign-extended immediates and fixed instruction fields.
  always_comb begin
    opcode = instr_i[6:0];
    funct3 = instr_i[14:12];
    b_imm  = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    j_imm  = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    i_imm  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  end

  // Branch condition and next-PC target. All adds wrap modulo 2^XLEN.
  always_comb begin
    pc_plus4 = pc_q + XLEN'(4);
    jalr_sum = rs1_i + i_imm;
    br_cond  = 1'b0;
    taken    = 1'b0;
    target   = pc_plus4;
    case (funct3)
      3'b000:  br_cond = (rs1_i == rs2_i);
      3'b001:  br_cond = (rs1_i != rs2_i);
      3'b100:  br_cond = ($signed(rs1_i) <  $signed(rs2_i));
      3'b101:  br_cond = ($signed(rs1_i) >= $signed(rs2_i));
      3'b110:  br_cond = (rs1_i <  rs2_i);
      3'b111:  br_cond = (rs1_i >= rs2_i);
      default: br_cond = 1'b0;
    endcase
    case (opcode)
      OP_BRANCH: begin
        if (br_cond) begin
          taken  = 1'b1;
          target = pc_q + b_imm;
        end
      end
      OP_JAL: begin
        taken  = 1'b1;
        target = pc_q + j_imm;
      end
      OP_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: begin
        taken  = 1'b0;
        target = pc_plus4;
      end
    endcase
  end

  // Stage sequencing, PC update, retire pulse and sticky trap.
  always_comb begin
    is_last  = (stage_q == LAST_STAGE);
    advance  = !stall_i && !trap_q;
`ifdef MISALIGN_TRAP_EN
    misalign = taken && (target[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    stage_d  = stage_q;
    pc_d     = pc_q;
    retire_d = 1'b0;
    trap_d   = trap_q;
    if (advance) begin
      if (!is_last) begin
        stage_d = stage_q + STW'(1);
      end else begin
        stage_d = '0;
        if (misalign) begin
          // A faulting instruction keeps its PC and does not retire.
          trap_d = 1'b1;
        end else begin
          pc_d     = target;
          retire_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= '0;
      pc_q     <= PC_INIT;
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
    end
  end

  // Output mapping.
  always_comb begin
    stage_o    = stage_q;
    advance_o  = advance;
    pc_o       = pc_q;
    link_o     = pc_plus4;
    redirect_o = is_last && advance && taken;
    retire_o   = retire_q;
    trap_o     = trap_q;
  end

endmodule
